button_gesture: RTL and testbench
=================================

Name: button_gesture

Overview:
- Gesture decoder directly downstream of the debounce/synchroniser stage; consumes its clean, synchronous debounced button level.
- Classifies each press into one of three gestures: short press, long press, double-click.
- Each gesture is reported as a single-cycle pulse, plus a held level and a last-gesture register.
- Drives UI/mode-select logic on boards with only one or two pushbuttons.

Parameters:
- LONG_CYCLES, 1000: consecutive high samples required to declare a long press; legal range 2..2**CNTR_W-1.
- DCLICK_CYCLES, 250: consecutive low samples after a short press before it is confirmed as short; a second press arriving earlier is a double-click; legal range 2..2**CNTR_W-1.
- CNTR_W, 16: width of the internal cycle counter.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  asynchronous, active-low reset.
- i_cg  input  1  clock gate; 1 = advance.
- i_button  input  1  debounced button level (1 = pressed); synchronous to i_clk.
- o_shortPress  output  1  one-cycle pulse: short press confirmed.
- o_longPress  output  1  one-cycle pulse: long press threshold reached.
- o_doubleClick  output  1  one-cycle pulse: second press within window.
- o_held  output  1  level: button still held after long press fired.
- o_lastGesture  output  2  0 = none, 1 = short, 2 = long, 3 = double; updated with each pulse.

Behaviour:
- Reset (i_rst=0, async): state=ARMWAIT, counter=0, all outputs 0, o_lastGesture=0.
- Reset mid-press: the FSM never reports a gesture for a press already in progress. ARMWAIT requires a low sample before arming.
- All state and counter flops advance only on edges where i_cg=1.
- Pulse flops update every edge with next value = event & i_cg. A pulse therefore lasts exactly one cycle and is never repeated while i_cg=0.
- o_lastGesture updates only on edges where a pulse is set.
- States and transitions (evaluated on each i_cg=1 edge):
  - ARMWAIT: i_button=0 -> IDLE.
  - IDLE: i_button=1 -> PRESS1, counter=1.
  - PRESS1:
    - i_button=1 and counter==LONG_CYCLES-1 -> HELD; set o_longPress.
    - i_button=1 otherwise -> counter+1.
    - i_button=0 -> GAP, counter=1.
  - GAP:
    - i_button=1 -> WAITREL; set o_doubleClick.
    - i_button=0 and counter==DCLICK_CYCLES-1 -> IDLE; set o_shortPress.
    - i_button=0 otherwise -> counter+1.
  - HELD: o_held=1 (registered, asserted from the edge entering HELD). i_button=0 -> IDLE; o_held clears on that edge.
  - WAITREL: i_button=0 -> IDLE. No further gesture is reported for this press, however long it is held.
- Timing, with the first high sample taken at edge e0:
  - o_longPress is high after edge e0+LONG_CYCLES-1, provided i_button=1 at every edge from e0 to e0+LONG_CYCLES-1.
  - A press of LONG_CYCLES-1 samples is short. A press of LONG_CYCLES samples is long.
- Releasing after a long press produces no short pulse.
- Double-click: the second press is sampled at GAP counter values 1..DCLICK_CYCLES-1, i.e. after at most DCLICK_CYCLES-1 low samples.
  - At exactly DCLICK_CYCLES low samples o_shortPress fires instead; a press at the next edge then starts a new PRESS1 from IDLE.
- Second press of a double-click never produces long/held.
- Counter never exceeds max(LONG_CYCLES, DCLICK_CYCLES)-1, so it cannot wrap.
- At most one pulse output is high in any cycle.
- Illegal parameters: elaboration-time assertion, using the codebase's standard assertion macros.

Test Plan:
Bench parameters: LONG_CYCLES=20, DCLICK_CYCLES=8, CNTR_W=8, i_cg=1 unless stated.
- Short: hold i_button=1 for 5 cycles, then 0.
  - o_shortPress high for one cycle after the 8th low sample.
  - o_lastGesture=1.
  - No other pulse.
- Long boundary:
  - 19 high samples -> short path, o_shortPress after 8 lows.
  - 20 high samples -> o_longPress at the 20th sample edge; o_held=1 until release; no short pulse after release; o_lastGesture=2.
- Double-click window:
  - 3 high, 7 low, 3 high -> o_doubleClick at the edge sampling the second press; o_lastGesture=3.
  - Repeat with 8 low -> o_shortPress, then the second press becomes a new PRESS1.
- Reset mid-press:
  - Drive i_rst=0 while i_button=1 in PRESS1 -> all outputs 0 immediately.
  - Release reset with button still high for 30 cycles -> no o_longPress; arming happens only after the first low sample.
- Clock gate:
  - During PRESS1 drop i_cg for 10 cycles at press count 10 -> counting is frozen.
  - o_longPress fires after 10 further high, gated-on samples.
  - Drop i_cg on the edge where the event would fire -> no pulse, no duplicate pulse later.
- Long then double: long press, release, then press again within 3 cycles -> new PRESS1 (not a double-click), because HELD returns to IDLE, not GAP.

Source files
------------

// File: rtl/button_gesture_if.sv
// button_gesture_if: clock-gate/button inputs and gesture outputs of the gesture decoder.
interface button_gesture_if;
  logic       i_cg;
  logic       i_button;
  logic       o_shortPress;
  logic       o_longPress;
  logic       o_doubleClick;
  logic       o_held;
  logic [1:0] o_lastGesture;
  modport master (output i_cg, i_button, input o_shortPress, o_longPress, o_doubleClick, o_held, o_lastGesture);
  modport slave (input i_cg, i_button, output o_shortPress, o_longPress, o_doubleClick, o_held, o_lastGesture);
endinterface

// File: rtl/button_gesture.sv
// button_gesture: classifies debounced presses into short, long and double-click gestures.
module button_gesture #(
  parameter int LONG_CYCLES   = 1000,
  parameter int DCLICK_CYCLES = 250,
  parameter int CNTR_W        = 16
) (
  input logic             i_clk,
  input logic             i_rst,
  button_gesture_if.slave bus
);
  localparam logic [2:0] ARMWAIT = 3'd0;
  localparam logic [2:0] IDLE    = 3'd1;
  localparam logic [2:0] PRESS1  = 3'd2;
  localparam logic [2:0] GAP     = 3'd3;
  localparam logic [2:0] HELD    = 3'd4;
  localparam logic [2:0] WAITREL = 3'd5;
  localparam logic [CNTR_W-1:0] LONG_LAST   = CNTR_W'(LONG_CYCLES - 1);
  localparam logic [CNTR_W-1:0] DCLICK_LAST = CNTR_W'(DCLICK_CYCLES - 1);
  localparam logic [CNTR_W-1:0] CNT_ONE     = CNTR_W'(1);

  if (LONG_CYCLES < 2 || LONG_CYCLES > 2**CNTR_W - 1) begin : g_bad_long
    $error("button_gesture: LONG_CYCLES out of range");
  end
  if (DCLICK_CYCLES < 2 || DCLICK_CYCLES > 2**CNTR_W - 1) begin : g_bad_dclick
    $error("button_gesture: DCLICK_CYCLES out of range");
  end

  logic [2:0]        state_q, state_d;
  logic [CNTR_W-1:0] cnt_q, cnt_d;
  logic              short_q, short_d, long_q, long_d, dbl_q, dbl_d, held_q, held_d;
  logic [1:0]        last_q, last_d;
  logic              short_ev, long_ev, dbl_ev;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_ev = 1'b0;
    long_ev  = 1'b0;
    dbl_ev   = 1'b0;
    if (bus.i_cg) begin
      case (state_q)
        ARMWAIT: if (!bus.i_button) state_d = IDLE;
        IDLE: if (bus.i_button) begin
          state_d = PRESS1;
          cnt_d   = CNT_ONE;
        end
        PRESS1: if (!bus.i_button) begin
          state_d = GAP;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == LONG_LAST) begin
          state_d = HELD;
          long_ev = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
        GAP: if (bus.i_button) begin
          state_d = WAITREL;
          dbl_ev  = 1'b1;
        end else if (cnt_q == DCLICK_LAST) begin
          state_d  = IDLE;
          short_ev = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
        HELD, WAITREL: if (!bus.i_button) state_d = IDLE;
        default: state_d = ARMWAIT;
      endcase
    end
    short_d = short_ev & bus.i_cg;
    long_d  = long_ev & bus.i_cg;
    dbl_d   = dbl_ev & bus.i_cg;
    held_d  = state_d == HELD;
    last_d  = short_d ? 2'd1 : long_d ? 2'd2 : dbl_d ? 2'd3 : last_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ARMWAIT;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      held_q  <= 1'b0;
      last_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      held_q  <= held_d;
      last_q  <= last_d;
    end
  end

  assign bus.o_shortPress  = short_q;
  assign bus.o_longPress   = long_q;
  assign bus.o_doubleClick = dbl_q;
  assign bus.o_held        = held_q;
  assign bus.o_lastGesture = last_q;
endmodule

// File: tb/tb_button_gesture.sv
// tb_button_gesture: directed checks of the gesture decoder with LONG=20, DCLICK=8.
module tb_button_gesture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0, n_fail = 0;
  int sc = 0, lc = 0, dc = 0, multi = 0;

  button_gesture_if bus();

  button_gesture #(.LONG_CYCLES(20), .DCLICK_CYCLES(8), .CNTR_W(8)) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sc += int'(bus.o_shortPress);
    lc += int'(bus.o_longPress);
    dc += int'(bus.o_doubleClick);
    if (int'(bus.o_shortPress) + int'(bus.o_longPress) + int'(bus.o_doubleClick) > 1) multi++;
  endtask

  task automatic drive(input logic b, input int n);
    bus.i_button = b;
    repeat (n) tick();
  endtask

  task automatic clr();
    sc = 0;
    lc = 0;
    dc = 0;
  endtask

  initial begin
    bus.i_cg = 1'b1;
    bus.i_button = 1'b0;
    #12;
    chk("rst_short", int'(bus.o_shortPress), 0);
    chk("rst_long", int'(bus.o_longPress), 0);
    chk("rst_dbl", int'(bus.o_doubleClick), 0);
    chk("rst_held", int'(bus.o_held), 0);
    chk("rst_last", int'(bus.o_lastGesture), 0);
    #10 rst_n = 1'b1;
    drive(1'b0, 2);
    // short press: 5 high, pulse on the 8th low sample
    clr();
    drive(1'b1, 5);
    drive(1'b0, 7);
    chk("short_early", sc, 0);
    drive(1'b0, 1);
    chk("short_pulse", int'(bus.o_shortPress), 1);
    chk("short_last", int'(bus.o_lastGesture), 1);
    drive(1'b0, 3);
    chk("short_cnt", sc, 1);
    chk("short_nolong", lc, 0);
    chk("short_nodbl", dc, 0);
    // 19 high samples is still short
    clr();
    drive(1'b1, 19);
    chk("b19_nolong", lc, 0);
    drive(1'b0, 8);
    chk("b19_short", int'(bus.o_shortPress), 1);
    drive(1'b0, 2);
    chk("b19_cnt", sc, 1);
    // 20 high samples is long
    clr();
    drive(1'b1, 19);
    chk("b20_pre", lc, 0);
    drive(1'b1, 1);
    chk("b20_long", int'(bus.o_longPress), 1);
    chk("b20_held", int'(bus.o_held), 1);
    chk("b20_last", int'(bus.o_lastGesture), 2);
    drive(1'b1, 5);
    chk("b20_held_on", int'(bus.o_held), 1);
    drive(1'b0, 1);
    chk("b20_held_off", int'(bus.o_held), 0);
    drive(1'b0, 10);
    chk("b20_noshort", sc, 0);
    chk("b20_lcnt", lc, 1);
    // double click with 7 low samples
    clr();
    drive(1'b1, 3);
    drive(1'b0, 7);
    drive(1'b1, 1);
    chk("dbl_pulse", int'(bus.o_doubleClick), 1);
    chk("dbl_last", int'(bus.o_lastGesture), 3);
    drive(1'b1, 30);
    chk("dbl_held", int'(bus.o_held), 0);
    drive(1'b0, 10);
    chk("dbl_cnt", dc, 1);
    chk("dbl_nolong", lc, 0);
    chk("dbl_noshort", sc, 0);
    // 8 low samples: short, then the second press is a fresh PRESS1
    clr();
    drive(1'b1, 3);
    drive(1'b0, 8);
    chk("gap8_short", int'(bus.o_shortPress), 1);
    drive(1'b1, 1);
    chk("gap8_nodbl", int'(bus.o_doubleClick), 0);
    drive(1'b1, 18);
    chk("gap8_prelong", lc, 0);
    drive(1'b1, 1);
    chk("gap8_long", int'(bus.o_longPress), 1);
    drive(1'b0, 3);
    chk("gap8_dc", dc, 0);
    chk("gap8_sc", sc, 1);
    // reset mid-press
    drive(1'b1, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_last", int'(bus.o_lastGesture), 0);
    chk("mid_rst_held", int'(bus.o_held), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    drive(1'b1, 30);
    chk("mid_rst_nolong", lc, 0);
    chk("mid_rst_noheld", int'(bus.o_held), 0);
    drive(1'b0, 1);
    drive(1'b1, 20);
    chk("arm_long", lc, 1);
    drive(1'b0, 3);
    // clock gate freezes counting at press count 10
    clr();
    drive(1'b1, 10);
    bus.i_cg = 1'b0;
    drive(1'b1, 10);
    bus.i_cg = 1'b1;
    chk("cg_frozen", lc, 0);
    drive(1'b1, 9);
    chk("cg_pre", lc, 0);
    drive(1'b1, 1);
    chk("cg_long", int'(bus.o_longPress), 1);
    drive(1'b0, 2);
    // gate dropped on the firing edge
    clr();
    drive(1'b1, 19);
    bus.i_cg = 1'b0;
    drive(1'b1, 1);
    chk("cg_edge_none", int'(bus.o_longPress), 0);
    drive(1'b1, 5);
    chk("cg_edge_hold", lc, 0);
    bus.i_cg = 1'b1;
    drive(1'b1, 1);
    chk("cg_edge_fire", int'(bus.o_longPress), 1);
    drive(1'b1, 5);
    chk("cg_edge_once", lc, 1);
    drive(1'b0, 2);
    // long press then quick re-press is a new PRESS1
    clr();
    drive(1'b1, 20);
    drive(1'b0, 2);
    drive(1'b1, 1);
    chk("ld_nodbl", int'(bus.o_doubleClick), 0);
    drive(1'b1, 19);
    chk("ld_long2", lc, 2);
    drive(1'b0, 10);
    chk("ld_dc", dc, 0);
    chk("ld_sc", sc, 0);
    chk("one_hot", multi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
